// File: rtl/pacman_mover.sv
// Tile-stepping Pacman movement controller: turns toward the wanted direction when the maze allows, else keeps going.
// Define PACMAN_TUNNEL_WRAP_EN to let targets one past a border wrap to the opposite border.
module pacman_mover #(
   parameter int BORDER_X_MIN = 1,
   parameter int BORDER_X_MAX = 28,
   parameter int BORDER_Y_MIN = 1,
   parameter int BORDER_Y_MAX = 28,
   parameter int START_X      = 14,
   parameter int START_Y      = 20,
   parameter int START_DIR    = 1,
   parameter int STEP_FRAMES  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce,
   input  logic       joy_valid,
   input  logic [1:0] joy_dir,
   output logic [4:0] map_x,
   output logic [4:0] map_y,
   input  logic       map_wall,
   output logic [4:0] xpos,
   output logic [4:0] ypos,
   output logic [1:0] direction,
   output logic       moving,
   output logic       step_done
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] Q_WANT = 3'd1;
   localparam logic [2:0] R_WANT = 3'd2;
   localparam logic [2:0] Q_CUR  = 3'd3;
   localparam logic [2:0] R_CUR  = 3'd4;

   localparam logic [4:0] XMIN = 5'(BORDER_X_MIN);
   localparam logic [4:0] XMAX = 5'(BORDER_X_MAX);
   localparam logic [4:0] YMIN = 5'(BORDER_Y_MIN);
   localparam logic [4:0] YMAX = 5'(BORDER_Y_MAX);
   localparam logic [7:0] STEP_LAST = 8'(STEP_FRAMES - 1);

   logic [2:0] state;
   logic [7:0] frame_cnt;
   logic [1:0] want_dir;
   logic [1:0] snap_dir;
   logic       step_req;
   logic [9:0] want_tgt;
   logic [9:0] cur_tgt;
   logic       want_free;
   logic       cur_free;

   // Neighbour tile {x, y} one step in dir, 5-bit wraparound arithmetic.
   function automatic logic [9:0] neighbour(input logic [1:0] dir, input logic [4:0] x,
                                            input logic [4:0] y);
      logic [4:0] nx;
      logic [4:0] ny;
      nx = x;
      ny = y;
      case (dir)
         2'd0:    ny = y - 5'd1;
         2'd1:    nx = x - 5'd1;
         2'd2:    ny = y + 5'd1;
         default: nx = x + 5'd1;
      endcase
`ifdef PACMAN_TUNNEL_WRAP_EN
      if (dir == 2'd1 && x == XMIN) nx = XMAX;
      if (dir == 2'd3 && x == XMAX) nx = XMIN;
      if (dir == 2'd0 && y == YMIN) ny = YMAX;
      if (dir == 2'd2 && y == YMAX) ny = YMIN;
`endif
      return {nx, ny};
   endfunction

   function automatic logic in_window(input logic [9:0] t);
      return (t[9:5] >= XMIN) && (t[9:5] <= XMAX) && (t[4:0] >= YMIN) && (t[4:0] <= YMAX);
   endfunction

   assign step_req  = ce && (frame_cnt == STEP_LAST);
   assign want_tgt  = neighbour(snap_dir, xpos, ypos);
   assign cur_tgt   = neighbour(direction, xpos, ypos);
   assign want_free = !map_wall && in_window(want_tgt);
   assign cur_free  = !map_wall && in_window(cur_tgt);

   always_comb begin
      map_x = xpos;
      map_y = ypos;
      case (state)
         Q_WANT, R_WANT: {map_x, map_y} = want_tgt;
         Q_CUR, R_CUR:   {map_x, map_y} = cur_tgt;
         default: ;
      endcase
   end

   // Snapshot is taken from the register, so a joystick update on the same clk is not seen.
   always_ff @(posedge clk) begin
      if (state == IDLE && step_req) snap_dir <= want_dir;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         frame_cnt <= 8'd0;
         want_dir  <= 2'(START_DIR);
         xpos      <= 5'(START_X);
         ypos      <= 5'(START_Y);
         direction <= 2'(START_DIR);
         moving    <= 1'b0;
         step_done <= 1'b0;
      end else begin
         step_done <= 1'b0;
         if (joy_valid) want_dir <= joy_dir;
         if (ce) frame_cnt <= step_req ? 8'd0 : frame_cnt + 8'd1;
         case (state)
            IDLE:   if (step_req) state <= Q_WANT;
            Q_WANT: state <= R_WANT;
            R_WANT: begin
               if (want_free) begin
                  {xpos, ypos} <= want_tgt;
                  direction    <= snap_dir;
                  moving       <= 1'b1;
                  step_done    <= 1'b1;
                  state        <= IDLE;
               end else begin
                  state <= Q_CUR;
               end
            end
            Q_CUR:  state <= R_CUR;
            R_CUR: begin
               if (cur_free) begin
                  {xpos, ypos} <= cur_tgt;
                  moving       <= 1'b1;
               end else begin
                  moving <= 1'b0;
               end
               step_done <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/pacman_mover.md
PACMAN_MOVER -- requirements
Module: pacman_mover

Interface
REQ-001 SHALL have parameter BORDER_X_MIN, default 1, lowest legal tile column.
REQ-002 SHALL have parameter BORDER_X_MAX, default 28, highest legal tile column.
REQ-003 SHALL have parameter BORDER_Y_MIN, default 1, lowest legal tile row.
REQ-004 SHALL have parameter BORDER_Y_MAX, default 28, highest legal tile row.
REQ-005 SHALL have parameters START_X (default 14), START_Y (default 20), START_DIR (default 1): reset position and facing.
REQ-006 SHALL have parameter STEP_FRAMES, default 8, range 1..255: ce ticks per movement step.
REQ-007 clk  in  1  sole clock; all state on its rising edge.
REQ-008 rst_n  in  1  reset; asynchronous, active-low.
REQ-009 ce  in  1  frame-tick enable, one clk wide per frame.
REQ-010 joy_valid  in  1  joystick direction present this clk.
REQ-011 joy_dir  in  2  requested direction: 0 up (y-1), 1 left (x-1), 2 down (y+1), 3 right (x+1).
REQ-012 map_x  out  5  tile column presented to the maze map.
REQ-013 map_y  out  5  tile row presented to the maze map.
REQ-014 map_wall  in  1  wall flag for the tile addressed on the previous clk (registered ROM, 1-clk latency).
REQ-015 xpos  out  5  current tile column; feeds the Pacman sprite renderer.
REQ-016 ypos  out  5  current tile row; feeds the Pacman sprite renderer.
REQ-017 direction  out  2  current facing, same encoding as joy_dir.
REQ-018 moving  out  1  high when the most recent step attempt moved the sprite.
REQ-019 step_done  out  1  one-clk pulse when a step attempt completes.

Function
REQ-020 want_dir register SHALL load joy_dir on every clk with joy_valid=1, in any state.
REQ-021 frame_cnt (8 bit) SHALL increment on each ce; when ce=1 and frame_cnt=STEP_FRAMES-1, it SHALL clear to 0 and raise a step request.
REQ-022 States: IDLE, Q_WANT, R_WANT, Q_CUR, R_CUR; a step request in IDLE SHALL enter Q_WANT; a step request in any other state SHALL be dropped.
REQ-023 On entering Q_WANT, want_dir SHALL be snapshotted; a joy_valid in the same clk updates want_dir but not the snapshot.
REQ-024 Q_WANT SHALL drive map_x/map_y with the neighbour tile in the snapshot direction, then go to R_WANT unconditionally.
REQ-025 R_WANT: if target is free, SHALL update xpos/ypos to the target, direction to the snapshot, moving=1, pulse step_done, go IDLE; otherwise SHALL go Q_CUR.
REQ-026 Q_CUR SHALL drive the neighbour tile in the current direction, then go to R_CUR.
REQ-027 R_CUR: if free, SHALL move as REQ-025 keeping direction; else SHALL hold position, set moving=0, pulse step_done, go IDLE.
REQ-028 Target is free when map_wall=0 and the target lies inside the border window; target coordinates use 5-bit arithmetic.
REQ-029 Latency: with the step-triggering ce on edge N, an accepted want move SHALL be visible after edge N+2 and a fallback move after edge N+4.
REQ-030 In IDLE, map_x/map_y SHALL hold xpos/ypos.

Reset
REQ-031 rst_n low SHALL immediately force xpos=START_X, ypos=START_Y, direction=START_DIR, want_dir=START_DIR, moving=0, step_done=0, frame_cnt=0, state IDLE, including mid-step.

Configuration
REQ-032 Macro PACMAN_TUNNEL_WRAP_EN defined: a target one past a border SHALL wrap to the opposite border (e.g. x=BORDER_X_MIN moving left targets BORDER_X_MAX), queried against the map normally.
REQ-033 PACMAN_TUNNEL_WRAP_EN undefined: a target outside the border window SHALL be blocked regardless of map_wall.

Verification
REQ-034 Reset, open map, joy_dir=3, 8 ce ticks -> xpos 14->15, ypos=20, direction=3, moving=1, step_done once, 2 clk after 8th ce.
REQ-035 Facing 1, want 0, wall above, free left -> xpos 14->13, direction stays 1, update 4 clk after triggering ce.
REQ-036 Wall both want and current directions -> xpos/ypos unchanged, moving=0, step_done pulses.
REQ-037 x=1 moving left, open map -> wrap build: xpos=28; non-wrap build: xpos stays 1, moving=0.
REQ-038 rst_n low during R_WANT -> outputs at reset values immediately; next step needs a full 8 ce ticks.
REQ-039 STEP_FRAMES=1, ce every clk -> requests arriving in non-IDLE states dropped; exactly one step_done per 3 clk.
